// File: rtl/edge_evt_pkg.sv
// Shared types and helpers for the edge-event arbiter and related schedulers.
package edge_evt_pkg;

  localparam int MAX_CH = 16;

  function automatic int ch_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Sized for the largest supported channel count; the top trims to its own width.
  localparam int CH_IDX_W = ch_idx_w(MAX_CH);

  typedef enum logic {EMPTY, HOLD} evt_state_t;

  typedef struct packed {
    logic [CH_IDX_W-1:0] ch;
    logic                ovf;
  } evt_t;

endpackage

// File: rtl/edge_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        idx = W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller with round-robin valid/ready output.
// Optional per-event timestamps are enabled with the EVT_TIMESTAMP_EN macro.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int TS_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         ch_in,
  input  logic [N_CH-1:0]         ch_en,
  input  logic [N_CH-1:0]         ch_mode,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [$clog2(N_CH)-1:0] evt_ch,
  output logic                    evt_ovf,
  output logic [N_CH-1:0]         pending
`ifdef EVT_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]         evt_ts
`endif
);

  localparam int IDX_W = $clog2(N_CH);

  logic [N_CH-1:0]  s1_reg, s2_reg, prev_reg;
  logic [1:0]       warm_cnt_reg;
  logic             warm;
  logic [N_CH-1:0]  pend_reg, ovf_reg;
  logic [N_CH-1:0]  edge_vec, grant_vec;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             grant;
  evt_state_t       state_reg, state_next;
  evt_t             evt_reg, evt_next;
  logic             valid_reg, valid_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_reg       <= '0;
      s2_reg       <= '0;
      prev_reg     <= '0;
      warm_cnt_reg <= '0;
    end else begin
      s1_reg   <= ch_in;
      s2_reg   <= s1_reg;
      prev_reg <= s2_reg;
      if (warm_cnt_reg != 2'd3) warm_cnt_reg <= warm_cnt_reg + 2'd1;
    end
  end

  // Unmask only once prev has caught up with s2, so lines high at reset stay silent.
  assign warm = (warm_cnt_reg == 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign edge_vec[gi] = ch_en[gi] & warm &
                            (ch_mode[gi] ? (s2_reg[gi] ^ prev_reg[gi])
                                         : (s2_reg[gi] & ~prev_reg[gi]));
      assign grant_vec[gi] = grant & (win_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_reg <= '0;
      ovf_reg  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!ch_en[i]) begin
          pend_reg[i] <= 1'b0;
          ovf_reg[i]  <= 1'b0;
        end else if (grant_vec[i]) begin
          pend_reg[i] <= edge_vec[i];
          ovf_reg[i]  <= 1'b0;
        end else if (edge_vec[i]) begin
          if (pend_reg[i]) ovf_reg[i] <= 1'b1;
          pend_reg[i] <= 1'b1;
        end
      end
    end
  end

  rr_pick #(.N(N_CH), .W(IDX_W)) u_rr_pick (
    .req (pend_reg),
    .ptr (ptr_reg),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    state_next = state_reg;
    valid_next = valid_reg;
    evt_next   = evt_reg;
    grant      = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (win_any) begin
          grant        = 1'b1;
          evt_next.ch  = CH_IDX_W'(win_idx);
          evt_next.ovf = ovf_reg[win_idx];
          valid_next   = 1'b1;
          state_next   = HOLD;
        end
      end
      HOLD: begin
        if (evt_ready) begin
          if (win_any) begin
            grant        = 1'b1;
            evt_next.ch  = CH_IDX_W'(win_idx);
            evt_next.ovf = ovf_reg[win_idx];
          end else begin
            valid_next = 1'b0;
            state_next = EMPTY;
          end
        end
      end
      default: begin
        state_next = EMPTY;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= EMPTY;
      valid_reg <= 1'b0;
      evt_reg   <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
      evt_reg   <= evt_next;
      if (grant) ptr_reg <= (win_idx == IDX_W'(N_CH - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  assign evt_valid = valid_reg;
  assign evt_ch    = evt_reg.ch[IDX_W-1:0];
  assign evt_ovf   = evt_reg.ovf;
  assign pending   = pend_reg;

  logic unused_ch_bits;
  assign unused_ch_bits = &{1'b0, evt_reg.ch};

`ifdef EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_reg;
  logic [TS_W-1:0] ts_reg [N_CH];
  logic [TS_W-1:0] evt_ts_reg;

  // Capture only when an edge opens a new event; overflow keeps the oldest stamp.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_cnt_reg <= '0;
      evt_ts_reg <= '0;
      for (int i = 0; i < N_CH; i++) ts_reg[i] <= '0;
    end else begin
      ts_cnt_reg <= ts_cnt_reg + 1'b1;
      if (grant) evt_ts_reg <= ts_reg[win_idx];
      for (int i = 0; i < N_CH; i++) begin
        if (edge_vec[i] && (!pend_reg[i] || grant_vec[i])) ts_reg[i] <= ts_cnt_reg;
      end
    end
  end

  assign evt_ts = evt_ts_reg;
`else
  localparam int unused_ts_w = TS_W;
`endif

endmodule
